// File: rtl/uart_wide_tx.sv
// Wide-word UART transmitter: latches one WORD_BYTES-byte word and sends it as back-to-back 8N1 frames.
// Optional even parity bit after bit 7 when UART_TX_PARITY_EN is defined (8E1 frames).
module uart_wide_tx #(
  parameter int WORD_BYTES   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    u_tx,
  output logic                    byte_done,
  output logic                    word_done,
  output logic                    busy
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(WORD_BYTES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  logic [2:0]    state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]    bit_r;
  logic [IW-1:0] byte_idx_r;
  logic [WW-1:0] word_r;
  logic          u_tx_r;
  logic          in_ready_r;
  logic          busy_r;
  logic          byte_done_r;
  logic          word_done_r;
  logic [7:0]    cur_byte_s;

  // The byte on the wire is always at the leading end of the latched word; it shifts after each stop bit.
  assign cur_byte_s = MSB_FIRST ? word_r[WW-1 -: 8] : word_r[7:0];

  // Frame sequencer: u_tx is loaded with the value of the bit that starts on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      baud_r      <= '0;
      bit_r       <= 3'd0;
      byte_idx_r  <= '0;
      word_r      <= '0;
      u_tx_r      <= 1'b1;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      byte_done_r <= 1'b0;
      word_done_r <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      word_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          baud_r <= '0;
          bit_r  <= 3'd0;
          if (in_valid && in_ready_r) begin
            word_r     <= data_in;
            byte_idx_r <= '0;
            state_r    <= S_START;
            u_tx_r     <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            u_tx_r <= 1'b1;
          end
        end
        default: begin
          if (baud_r != BAUD_LAST) begin
            baud_r <= baud_r + BW'(1'b1);
          end else begin
            baud_r <= '0;
            case (state_r)
              S_START: begin
                state_r <= S_DATA;
                bit_r   <= 3'd0;
                u_tx_r  <= cur_byte_s[0];
              end
              S_DATA: begin
                if (bit_r != 3'd7) begin
                  bit_r  <= bit_r + 3'd1;
                  u_tx_r <= cur_byte_s[bit_r + 3'd1];
                end else begin
`ifdef UART_TX_PARITY_EN
                  state_r <= S_PARITY;
                  u_tx_r  <= even_parity(cur_byte_s);
`else
                  state_r <= S_STOP;
                  u_tx_r  <= 1'b1;
`endif
                end
              end
              S_PARITY: begin
                state_r <= S_STOP;
                u_tx_r  <= 1'b1;
              end
              S_STOP: begin
                byte_done_r <= 1'b1;
                if (byte_idx_r == BYTE_LAST) begin
                  state_r     <= S_IDLE;
                  byte_idx_r  <= '0;
                  u_tx_r      <= 1'b1;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  word_done_r <= 1'b1;
                end else begin
                  state_r    <= S_START;
                  byte_idx_r <= byte_idx_r + IW'(1'b1);
                  word_r     <= MSB_FIRST ? (word_r << 8'd8) : (word_r >> 8'd8);
                  u_tx_r     <= 1'b0;
                end
              end
              default: begin
                // Unreachable encoding: fall back to a clean idle line.
                state_r    <= S_IDLE;
                u_tx_r     <= 1'b1;
                in_ready_r <= 1'b1;
                busy_r     <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign u_tx      = u_tx_r;
  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign byte_done = byte_done_r;
  assign word_done = word_done_r;

endmodule
